biquad_cascade_seq: RTL and testbench
=====================================

Name: biquad_cascade_seq

Overview:
- Time-multiplexed, single-MAC cascade of direct-form-II biquad sections with run-time programmable coefficients.
- Successor to the fixed-coefficient IIR datapath muxing:
  - width, fraction and section count are parameters;
  - coefficients sit in a writable register file instead of constants;
  - the block sequences its own operands and handshakes samples in and out.

Parameters:
- N, 24: sample/coefficient width; signed two's complement, Q(N-F-1).F.
- F, 14: fractional bits.
- SECTIONS, 2: number of cascaded biquad sections (1..8).
- GUARD, 4: extra accumulator MSBs; accumulator width is 2N+GUARD.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  N  input sample u.
- in_valid  in  1  input sample present.
- in_ready  out  1  block accepts a sample.
- out_data  out  N  filtered sample y of the last section.
- out_valid  out  1  out_data valid; held until accepted.
- out_ready  in  1  downstream accepts out_data.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  6  coefficient index = sec*5 + k, where k: 0=a1, 1=a2, 2=b0, 3=b1, 4=b2.
- coef_data  in  N  coefficient value.
- clr_state  in  1  synchronous clear of all delay registers f1/f2.

Behaviour:
- Per-section equations: f = u + a1*f1 + a2*f2; y = b0*f + b1*f1 + b2*f2. Section s output is section s+1 input u.
- FSM states: IDLE, A1, A2, FK, B0, B1, B2, UPD, DONE.
  - IDLE: in_ready=1. On in_valid, latch u, set sec=0, go A1.
  - A1: acc <= (u sign-extended <<< F) + a1*f1.
  - A2: acc += a2*f2.
  - FK: f <= fmt(acc).
  - B0: acc <= b0*f.
  - B1: acc += b1*f1.
  - B2: acc += b2*f2.
  - UPD: y <= fmt(acc); f2[sec] <= f1[sec]; f1[sec] <= f. If sec<SECTIONS-1: u <= y, sec++, go A1. Otherwise go DONE.
  - DONE: out_valid=1, out_data=y. On out_ready go IDLE. in_ready is next high one cycle after the handshake.
- Latency: 7*SECTIONS cycles from the input handshake to out_valid rising (14 at defaults).
- fmt(acc): arithmetic shift right by F (floor; no rounding), then reduce to N bits. Wrap or saturate per the optional feature.
- in_ready is 0 in every state except IDLE. There is no input buffering.
- Coefficient writes:
  - Accepted only in IDLE or DONE; ignored in any other state.
  - Addresses >= 5*SECTIONS are ignored.
  - A write issued in the same cycle as an input handshake is applied before A1 reads.
- clr_state:
  - Zeroes every f1/f2 in IDLE or DONE.
  - If asserted during a computation, it is deferred and applied on entry to IDLE; the current sample completes with old state.
- Reset values:
  - FSM=IDLE; in_ready=1; out_valid=0; out_data=0.
  - All f1/f2=0; acc=0; sec=0.
  - All coefficients 0 except b0 = 1<<F in every section, so the reset cascade is an exact passthrough.
- Reset is asynchronous at any state. A sample in progress is discarded and out_valid drops immediately.

Optional Feature:
- Macro BIQUAD_SAT_EN.
  - Defined: fmt() clamps to [-2^(N-1), 2^(N-1)-1] for both f and y.
  - Undefined: fmt() keeps the low N bits after the shift (two's-complement wrap).
- The accumulator never overflows internally in either mode (GUARD bits).

Test Plan:
1. Reset defaults, then in_data=0x000100 with out_ready=1 -> out_data=0x000100, out_valid high exactly 14 cycles after the handshake, in_ready low throughout.
2. Program section 0 = {a1 16957, a2 -6026, b0 9841, b1 -19677, b2 9841}, section 1 passthrough. Inputs 16384 then 0 -> outputs 9841 then -9492.
3. Hold out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0, a second in_valid is not accepted. Release -> in_ready=1 on the following cycle.
4. Coefficient write of b0=0 to section 0 while in state B1 -> ignored; the current and next outputs are unchanged. The same write in IDLE -> next output=0.
5. SECTIONS=1, a=0, b0=32767, b1=b2=0, in_data=8388607 -> 8388607 with BIQUAD_SAT_EN, -514 without.
6. Assert reset during B0 -> out_valid=0, in_ready=1 immediately. A following passthrough-config sample 0x000010 -> 0x000010, proving f1/f2 were cleared.

Source files
------------

// File: rtl/biquad_cascade_seq.sv
// Time-multiplexed single-MAC cascade of direct-form-II biquads, programmable coefficients.
// Define BIQUAD_SAT_EN to saturate fmt() results instead of wrapping them.
module biquad_cascade_seq #(
    parameter int N        = 24,
    parameter int F        = 14,
    parameter int SECTIONS = 2,
    parameter int GUARD    = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    input  logic         coef_we,
    input  logic [5:0]   coef_addr,
    input  logic [N-1:0] coef_data,
    input  logic         clr_state
);

    localparam int AW = 2*N + GUARD;
    localparam int NC = 5*SECTIONS;
    localparam int CW = $clog2(NC);
    localparam int SW = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
    localparam logic [N-1:0] B0_ONE = {{(N-1){1'b0}}, 1'b1} << F;

    typedef enum logic [3:0] {
        S_IDLE, S_A1, S_A2, S_FK, S_B0, S_B1, S_B2, S_UPD, S_DONE
    } state_t;

    state_t                state_q;
    logic [SW-1:0]         sec_q;
    logic signed [N-1:0]   u_q;
    logic signed [N-1:0]   f_q;
    logic signed [AW-1:0]  acc_q;
    logic [N-1:0]          out_data_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic                  clr_pend_q;
    logic signed [N-1:0]   f1_q [SECTIONS];
    logic signed [N-1:0]   f2_q [SECTIONS];
    logic signed [N-1:0]   coef_q [NC];

    logic                  busy;
    logic [2:0]            k_sel;
    logic [CW-1:0]         cidx;
    logic signed [N-1:0]   coef_sel;
    logic signed [N-1:0]   op_x;
    logic signed [2*N-1:0] prod;
    logic signed [AW-1:0]  prod_ext;
    logic signed [AW-1:0]  u_sh;
    logic signed [N-1:0]   fmt_v;

    assign busy      = !(state_q == S_IDLE || state_q == S_DONE);
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Pick the coefficient and delay-line operand for the MAC step of this state
    always_comb begin
        k_sel = 3'd0;
        op_x  = '0;
        unique case (state_q)
            S_A1: begin k_sel = 3'd0; op_x = f1_q[sec_q]; end
            S_A2: begin k_sel = 3'd1; op_x = f2_q[sec_q]; end
            S_B0: begin k_sel = 3'd2; op_x = f_q;         end
            S_B1: begin k_sel = 3'd3; op_x = f1_q[sec_q]; end
            S_B2: begin k_sel = 3'd4; op_x = f2_q[sec_q]; end
            default: begin k_sel = 3'd0; op_x = '0; end
        endcase
    end

    assign cidx     = CW'(sec_q * 5 + k_sel);
    assign coef_sel = coef_q[cidx];
    assign prod     = (2*N)'(coef_sel) * (2*N)'(op_x);
    assign prod_ext = {{GUARD{prod[2*N-1]}}, prod};
    assign u_sh     = {{(AW-N){u_q[N-1]}}, u_q} << F;

`ifdef BIQUAD_SAT_EN
    localparam logic signed [AW-1:0] MAXV = {{(AW-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = {{(AW-N+1){1'b1}}, {(N-1){1'b0}}};
    logic signed [AW-1:0] sh;
    assign sh = acc_q >>> F;

    // Floor-shift the accumulator and clamp it into the N-bit range
    always_comb begin
        fmt_v = sh[N-1:0];
        if (sh > MAXV) begin
            fmt_v = {1'b0, {(N-1){1'b1}}};
        end else if (sh < MINV) begin
            fmt_v = {1'b1, {(N-1){1'b0}}};
        end
    end
`else
    // Floor-shift the accumulator and keep the low N bits (wrap)
    always_comb begin
        fmt_v = N'(acc_q >>> F);
    end
`endif

    // Coefficient register file, writable only while no sample is in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NC; i++) begin
                coef_q[i] <= (i % 5 == 2) ? B0_ONE : '0;
            end
        end else if (coef_we && !busy && coef_addr < 6'(NC)) begin
            coef_q[coef_addr[CW-1:0]] <= coef_data;
        end
    end

    // Sequencer FSM with MAC accumulator, delay lines and registered handshakes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            sec_q       <= '0;
            u_q         <= '0;
            f_q         <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            clr_pend_q  <= 1'b0;
            for (int i = 0; i < SECTIONS; i++) begin
                f1_q[i] <= '0;
                f2_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (clr_state || clr_pend_q) begin
                        for (int i = 0; i < SECTIONS; i++) begin
                            f1_q[i] <= '0;
                            f2_q[i] <= '0;
                        end
                        clr_pend_q <= 1'b0;
                    end
                    if (in_valid) begin
                        u_q        <= in_data;
                        sec_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_A1;
                    end
                end
                S_A1: begin
                    acc_q   <= u_sh + prod_ext;
                    state_q <= S_A2;
                end
                S_A2: begin
                    acc_q   <= acc_q + prod_ext;
                    state_q <= S_FK;
                end
                S_FK: begin
                    f_q     <= fmt_v;
                    state_q <= S_B0;
                end
                S_B0: begin
                    acc_q   <= prod_ext;
                    state_q <= S_B1;
                end
                S_B1: begin
                    acc_q   <= acc_q + prod_ext;
                    state_q <= S_B2;
                end
                S_B2: begin
                    acc_q   <= acc_q + prod_ext;
                    state_q <= S_UPD;
                end
                S_UPD: begin
                    f2_q[sec_q] <= f1_q[sec_q];
                    f1_q[sec_q] <= f_q;
                    if (sec_q != SW'(SECTIONS-1)) begin
                        u_q     <= fmt_v;
                        sec_q   <= sec_q + 1'b1;
                        state_q <= S_A1;
                    end else begin
                        out_data_q  <= fmt_v;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (clr_state) begin
                        for (int i = 0; i < SECTIONS; i++) begin
                            f1_q[i] <= '0;
                            f2_q[i] <= '0;
                        end
                    end
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
            if (clr_state && busy) begin
                clr_pend_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_biquad_cascade_seq.sv
// Directed bench for biquad_cascade_seq at default parameters.
// Expected outputs are hand-computed for the Q9.14 format.
module tb_biquad_cascade_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        coef_we;
    logic [5:0]  coef_addr;
    logic [23:0] coef_data;
    logic        clr_state;

    int n_vec = 0;
    int n_err = 0;

    biquad_cascade_seq dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .clr_state (clr_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        coef_we   = 1'b1;
        coef_addr = 6'(a);
        coef_data = 24'(d);
        tick();
        coef_we   = 1'b0;
    endtask

    task automatic clr();
        clr_state = 1'b1;
        tick();
        clr_state = 1'b0;
    endtask

    task automatic hs(input int x);
        in_valid = 1'b1;
        in_data  = 24'(x);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat, output bit rdy_seen);
        lat = 0;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 60) begin
            if (in_ready) rdy_seen = 1'b1;
            tick();
            lat++;
        end
    endtask

    task automatic result(input string tag, input int exp);
        int lat;
        bit r;
        wait_out(lat, r);
        check({tag, "_valid"}, int'(out_valid), 1);
        check(tag, int'($signed(out_data)), exp);
        if (out_ready) tick();
    endtask

    initial begin
        int  lat;
        bit  rdy;
        int  sat_exp;
        reset     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        clr_state = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        reset = 1'b1;
        tick();

        // passthrough and latency
        hs(256);
        wait_out(lat, rdy);
        check("t1_latency", lat, 14);
        check("t1_in_ready_low", int'(rdy), 0);
        check("t1_valid", int'(out_valid), 1);
        check("t1_data", int'($signed(out_data)), 256);
        tick();

        // programmed section 0, impulse then zero
        clr();
        wr(0, 16957);
        wr(1, -6026);
        wr(2, 9841);
        wr(3, -19677);
        wr(4, 9841);
        hs(16384);
        result("t2_imp", 9841);
        hs(0);
        result("t2_zero", -9492);

        // back-pressure
        clr();
        out_ready = 1'b0;
        hs(16384);
        result("t3_first", 9841);
        in_valid = 1'b1;
        in_data  = 24'd777;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_hold_valid", int'(out_valid), 1);
            check("t3_hold_data", int'($signed(out_data)), 9841);
            check("t3_hold_in_ready", int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t3_rel_in_ready", int'(in_ready), 1);
        check("t3_rel_out_valid", int'(out_valid), 0);

        // coefficient write during B1 is ignored
        hs(0);
        repeat (4) tick();
        wr(2, 0);
        result("t4_busy_cur", -9492);
        clr();
        hs(16384);
        result("t4_busy_next", 9841);

        // write in the handshake cycle lands before A1
        clr();
        coef_we   = 1'b1;
        coef_addr = 6'd2;
        coef_data = 24'd0;
        in_valid  = 1'b1;
        in_data   = 24'd16384;
        tick();
        coef_we   = 1'b0;
        in_valid  = 1'b0;
        result("t4_idle_b0", 0);

        // overflow of fmt
        wr(0, 0);
        wr(1, 0);
        wr(2, 32767);
        wr(3, 0);
        wr(4, 0);
        clr();
`ifdef BIQUAD_SAT_EN
        sat_exp = 8388607;
`else
        sat_exp = -514;
`endif
        hs(8388607);
        result("t5_ovf", sat_exp);

        // asynchronous reset mid-computation
        hs(100);
        repeat (3) tick();
        #2 reset = 1'b0;
        #1;
        check("t6_out_valid", int'(out_valid), 0);
        check("t6_in_ready", int'(in_ready), 1);
        check("t6_out_data", int'(out_data), 0);
        #2 reset = 1'b1;
        tick();
        hs(16);
        result("t6_pass", 16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
